// File: rtl/nrf_spi_pkg.sv
// nrf_spi_pkg: shared SPI engine types and nRF24 constants (FSM states, NOP byte, commands, payload limit)
package nrf_spi_pkg;
  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_CMD, S_DATA, S_WAIT, S_END} state_t;
  localparam logic [7:0] NOP = 8'hFF;
  localparam logic [7:0] R_REGISTER = 8'h00;
  localparam logic [7:0] R_RX_PAYLOAD = 8'h61;
  localparam int MAX_LEN_DEF = 32;
endpackage

// File: rtl/spi_rx_if.sv
// spi_rx_if: control, handshake and SPI pin bundle of the nRF24 read engine
//   master: engine side (spi_rx); slave: controller/radio side
//   start_rx/cmd_in/len_in: transaction request; rx_data/rx_valid/rx_ready: byte stream out
//   sck/mosi_rx/csn_rx/miso_rx: SPI pins; busy/done_rx/status_out: transaction status
interface spi_rx_if #(parameter int LEN_W = 6);
  logic start_rx;
  logic [7:0] cmd_in;
  logic [LEN_W-1:0] len_in;
  logic miso_rx;
  logic rx_ready;
  logic sck;
  logic mosi_rx;
  logic csn_rx;
  logic [7:0] rx_data;
  logic rx_valid;
  logic busy;
  logic done_rx;
  logic [7:0] status_out;
  modport master (
    input start_rx, cmd_in, len_in, miso_rx, rx_ready,
    output sck, mosi_rx, csn_rx, rx_data, rx_valid, busy, done_rx, status_out
  );
  modport slave (
    output start_rx, cmd_in, len_in, miso_rx, rx_ready,
    input sck, mosi_rx, csn_rx, rx_data, rx_valid, busy, done_rx, status_out
  );
endinterface

// File: rtl/spi_sck_gen.sv
// spi_sck_gen: half-period counter producing SCK toggle strobes
//   clk_10/rst_n: clock, sync active-low reset; en: count half-periods; tgl: allow SCK edges
//   sck: current SCK level; tick: half-period ends; rise/fall: SCK goes high/low this cycle
module spi_sck_gen #(
  parameter int CLK_DIV = 2
) (
  input logic clk_10,
  input logic rst_n,
  input logic en,
  input logic tgl,
  input logic sck,
  output logic tick,
  output logic rise,
  output logic fall
);
  localparam int CW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  logic [CW-1:0] cnt;
  assign tick = en && cnt == CW'(CLK_DIV - 1);
  assign rise = tick && tgl && !sck;
  assign fall = tick && tgl && sck;
  always_ff @(posedge clk_10)
    if (!rst_n || !en || tick) cnt <= '0;
    else cnt <= cnt + CW'(1);
endmodule

// File: rtl/spi_rx.sv
// spi_rx: SPI mode-0 read engine for the nRF24L01 (command byte out, len_in payload bytes in)
//   clk_10/rst_n: clock, sync active-low reset; bus: spi_rx_if.master (request, SPI pins, byte stream)
//   SPI_RX_STATUS_EN: when defined, the byte clocked in during the command phase is held on status_out
module spi_rx
  import nrf_spi_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int MAX_LEN = MAX_LEN_DEF,
  parameter int LEN_W = 6
) (
  input logic clk_10,
  input logic rst_n,
  spi_rx_if.master bus
);
  state_t state, next;
  logic tick, rise, fall, en, tgl, byte_end, free;
  logic sck_q, csn_q, done_q, valid_q;
  logic [2:0] bit_cnt;
  logic [LEN_W-1:0] bytes, len_c;
  logic [7:0] tx_sr, sh, data_q;
  assign en = state inside {S_SETUP, S_CMD, S_DATA, S_END};
  assign tgl = state inside {S_CMD, S_DATA};
  assign byte_end = fall && bit_cnt == 3'd7;
  // output register can take a new byte now, or is being emptied this cycle
  assign free = !valid_q || bus.rx_ready;
  assign len_c = bus.len_in > LEN_W'(MAX_LEN) ? LEN_W'(MAX_LEN) : bus.len_in;
  spi_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck (
    .clk_10(clk_10),
    .rst_n(rst_n),
    .en(en),
    .tgl(tgl),
    .sck(sck_q),
    .tick(tick),
    .rise(rise),
    .fall(fall)
  );
  always_ff @(posedge clk_10)
    if (!rst_n) state <= S_IDLE;
    else state <= next;
  // a data byte loads the output register, so the next byte always waits for its handshake
  always_comb begin
    next = state;
    case (state)
      S_IDLE: next = bus.start_rx ? S_SETUP : S_IDLE;
      S_SETUP: next = tick ? S_CMD : S_SETUP;
      S_CMD: next = !byte_end ? S_CMD : bytes == '0 ? S_END : free ? S_DATA : S_WAIT;
      S_DATA: next = !byte_end ? S_DATA : bytes == LEN_W'(1) ? S_END : S_WAIT;
      S_WAIT: next = valid_q && bus.rx_ready ? S_DATA : S_WAIT;
      S_END: next = tick ? S_IDLE : S_END;
      default: next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk_10) begin
    if (!rst_n) begin
      sck_q <= 1'b0;
      csn_q <= 1'b1;
      done_q <= 1'b0;
      valid_q <= 1'b0;
      data_q <= '0;
      tx_sr <= '0;
      sh <= '0;
      bit_cnt <= '0;
      bytes <= '0;
    end else begin
      done_q <= state == S_END && tick;
      if (state == S_END && tick) csn_q <= 1'b1;
      if (state == S_IDLE && bus.start_rx) begin
        csn_q <= 1'b0;
        tx_sr <= bus.cmd_in;
        bytes <= len_c;
      end
      if (rise) begin
        sck_q <= 1'b1;
        sh <= {sh[6:0], bus.miso_rx};
      end
      if (fall) begin
        sck_q <= 1'b0;
        bit_cnt <= bit_cnt + 3'd1;
        tx_sr <= {tx_sr[6:0], 1'b1};
      end
      if (state == S_CMD && byte_end) tx_sr <= NOP;
      if (state == S_DATA && byte_end) begin
        data_q <= sh;
        valid_q <= 1'b1;
        bytes <= bytes - LEN_W'(1);
      end else if (valid_q && bus.rx_ready) valid_q <= 1'b0;
    end
  end
`ifdef SPI_RX_STATUS_EN
  logic [7:0] status_q;
  always_ff @(posedge clk_10)
    if (!rst_n) status_q <= '0;
    else if (state == S_CMD && byte_end) status_q <= sh;
  assign bus.status_out = status_q;
`else
  assign bus.status_out = 8'h00;
`endif
  assign bus.sck = sck_q;
  assign bus.mosi_rx = tx_sr[7];
  assign bus.csn_rx = csn_q;
  assign bus.busy = ~csn_q;
  assign bus.done_rx = done_q;
  assign bus.rx_valid = valid_q;
  assign bus.rx_data = data_q;
endmodule
